// File: rtl/seg_display_ctrl_pkg.sv
// Shared bus-side definitions for the seven-segment MMIO port, so the bus
// controller and the display controller agree on types and the port address.
package seg_display_ctrl_pkg;

    typedef logic [31:0] type_data;
    typedef logic [3:0]  type_nibble;
    typedef logic [6:0]  type_seg_code;

    // Word address of the seven-segment register in the MMIO map.
    localparam type_data P_SEG = 32'h0000_7f08;

endpackage

// File: rtl/seg_display_ctrl_if.sv
// Store port from the bus controller into the display controller: data plus
// a single-cycle write strobe, no backpressure.
interface seg_display_ctrl_if;
    import seg_display_ctrl_pkg::*;

    type_data iSeg;
    logic     iSegWe;

    modport master (output iSeg, output iSegWe);
    modport slave  (input  iSeg, input  iSegWe);
endinterface

// File: rtl/seg_display_ctrl_hex_decode.sv
// Hex nibble to active-low segment pattern {g,f,e,d,c,b,a}.
module seg_hex_decode
    import seg_display_ctrl_pkg::*;
(
    input  type_nibble   nib,
    output type_seg_code seg
);

    always_comb begin
        unique case (nib)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            4'hF: seg = 7'h0E;
        endcase
    end

endmodule

// File: rtl/seg_display_ctrl.sv
// Holds the last stored word and scans it as 8 hex digits onto a
// common-anode display, digit 0 = bits [3:0]; all pin outputs are registered.
module seg_display_ctrl
    import seg_display_ctrl_pkg::*;
#(
    parameter int SCAN_DIV = 100000,
    parameter bit BLANK_LZ = 1'b0
) (
    input  logic               clk,
    input  logic               rst,
    seg_display_ctrl_if.slave  bus,
    output logic [7:0]         oAn,
    output type_seg_code       oCa,
    output logic               oDp
);

    localparam int CNT_W = $clog2(SCAN_DIV);
    localparam logic [CNT_W-1:0] PRESC_LAST = CNT_W'(SCAN_DIV - 1);

    type_data         disp;
    logic [CNT_W-1:0] presc;
    logic [2:0]       idx;

    type_nibble       nib;
    type_seg_code     code;
    logic             blank;

    assign nib = disp[{idx, 2'b00} +: 4];

    seg_hex_decode u_hex_decode (
        .nib (nib),
        .seg (code)
    );

    // A digit above 0 is dark when it and every more significant nibble is zero.
    assign blank = BLANK_LZ && (idx != 3'd0) && ((disp >> {idx, 2'b00}) == '0);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values; a write and an index wrap on the same edge both land.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            disp  <= '0;
            presc <= '0;
            idx   <= '0;
        end else begin
            if (bus.iSegWe) begin
                disp <= bus.iSeg;
            end
            if (presc == PRESC_LAST) begin
                presc <= '0;
                idx   <= idx + 3'd1;
            end else begin
                presc <= presc + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            oAn <= 8'hFF;
            oCa <= 7'h7F;
            oDp <= 1'b1;
        end else begin
            oAn <= blank ? 8'hFF : ~(8'b1 << idx);
            oCa <= blank ? 7'h7F : code;
            oDp <= 1'b1;
        end
    end

endmodule

// File: tb/tb_seg_display_ctrl.sv
// Directed bench for seg_display_ctrl: two instances (plain and leading-zero
// blanking) checked every cycle against a slot/arithmetic model, plus literals.
module tb_seg_display_ctrl;

    localparam int DIV = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;

    seg_display_ctrl_if bus ();

    logic [7:0] an0, an1;
    logic [6:0] ca0, ca1;
    logic       dp0, dp1;

    seg_display_ctrl #(.SCAN_DIV(DIV), .BLANK_LZ(1'b0)) dut0 (
        .clk (clk), .rst (rst), .bus (bus.slave),
        .oAn (an0), .oCa (ca0), .oDp (dp0)
    );

    seg_display_ctrl #(.SCAN_DIV(DIV), .BLANK_LZ(1'b1)) dut1 (
        .clk (clk), .rst (rst), .bus (bus.slave),
        .oAn (an1), .oCa (ca1), .oDp (dp1)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: digit index is simply (edges since reset / DIV) mod 8; outputs
    // after an edge reflect the index and stored word seen just before it.
    logic [6:0] hex_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    int unsigned m_edges = 0;
    logic [31:0] m_disp  = '0;
    int unsigned m_slot;
    logic [7:0]  e_an0   = 8'hFF;
    logic [7:0]  e_an1   = 8'hFF;
    logic [6:0]  e_ca    = 7'h7F;
    logic        e_blank = 1'b0;
    bit          chk_on  = 1'b0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_edges = 0;
            m_disp  = '0;
            e_an0   = 8'hFF;
            e_an1   = 8'hFF;
            e_ca    = 7'h7F;
            e_blank = 1'b0;
        end else begin
            m_slot  = (m_edges / DIV) % 8;
            e_ca    = hex_tab[(m_disp >> (4 * m_slot)) & 32'hF];
            e_an0   = ~(8'd1 << m_slot);
            e_blank = (m_slot != 0) && ((m_disp >> (4 * m_slot)) == 0);
            e_an1   = e_blank ? 8'hFF : e_an0;
            if (bus.iSegWe) m_disp = bus.iSeg;
            m_edges++;
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            check("model_an", {24'd0, an0}, {24'd0, e_an0});
            check("model_ca", {25'd0, ca0}, {25'd0, e_ca});
            check("model_dp", {31'd0, dp0}, 32'd1);
            check("model_blank_an", {24'd0, an1}, {24'd0, e_an1});
            if (!e_blank) check("model_blank_ca", {25'd0, ca1}, {25'd0, e_ca});
            check("model_blank_dp", {31'd0, dp1}, 32'd1);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_word(input logic [31:0] d);
        step();
        bus.iSeg   = d;
        bus.iSegWe = 1'b1;
        step();
        bus.iSegWe = 1'b0;
    endtask

    task automatic wait_an0(input logic [7:0] v, input string tag);
        bit found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            step();
            if (an0 === v) found = 1'b1;
        end
        if (!found) check(tag, {24'd0, an0}, {24'd0, v});
    endtask

    initial begin
        bus.iSeg   = '0;
        bus.iSegWe = 1'b0;

        // Reset held for 3 cycles
        repeat (3) @(posedge clk);
        #1;
        check("rst_an", {24'd0, an0}, 32'hFF);
        check("rst_ca", {25'd0, ca0}, 32'h7F);
        check("rst_dp", {31'd0, dp0}, 32'd1);
        @(negedge clk);
        chk_on = 1'b1;
        #1 rst = 1'b1;
        step();
        check("first_an", {24'd0, an0}, 32'hFE);
        check("first_ca", {25'd0, ca0}, 32'h40);

        // Scan 0x76543210 for two full rounds
        write_word(32'h7654_3210);
        repeat (64) step();
        wait_an0(8'h7F, "wait_d7");
        check("scan_d7_ca", {25'd0, ca0}, 32'h78);
        wait_an0(8'hFB, "wait_d2");
        check("scan_d2_ca", {25'd0, ca0}, 32'h24);

        // Write latency inside the digit-0 slot
        wait_an0(8'h7F, "wait_d7b");
        wait_an0(8'hFE, "wait_d0");
        bus.iSeg   = 32'h0000_000F;
        bus.iSegWe = 1'b1;
        step();
        bus.iSegWe = 1'b0;
        check("lat_1edge_ca", {25'd0, ca0}, 32'h40);
        step();
        check("lat_2edge_ca", {25'd0, ca0}, 32'h0E);
        check("lat_2edge_an", {24'd0, an0}, 32'hFE);
        step();
        check("lat_slot_end_an", {24'd0, an0}, 32'hFE);
        step();
        check("lat_next_slot_an", {24'd0, an0}, 32'hFD);

        // Back-to-back strobes: the second word wins
        step();
        bus.iSeg   = 32'hAAAA_AAAA;
        bus.iSegWe = 1'b1;
        step();
        bus.iSeg   = 32'h8888_8888;
        step();
        bus.iSegWe = 1'b0;
        for (int i = 0; i < 32; i++) begin
            step();
            check("b2b_ca", {25'd0, ca0}, 32'h00);
        end

        // Leading-zero blanking
        write_word(32'h0000_0A05);
        wait_an0(8'h7F, "wait_bl7");
        wait_an0(8'hFE, "wait_bl0");
        check("bl_d0_an", {24'd0, an1}, 32'hFE);
        check("bl_d0_ca", {25'd0, ca1}, 32'h12);
        repeat (DIV) step();
        check("bl_d1_an", {24'd0, an1}, 32'hFD);
        check("bl_d1_ca", {25'd0, ca1}, 32'h40);
        repeat (DIV) step();
        check("bl_d2_an", {24'd0, an1}, 32'hFB);
        check("bl_d2_ca", {25'd0, ca1}, 32'h08);
        repeat (DIV) step();
        check("bl_d3_an", {24'd0, an1}, 32'hFF);
        write_word(32'h0000_0000);
        wait_an0(8'h7F, "wait_z7");
        wait_an0(8'hFE, "wait_z0");
        check("zero_d0_an", {24'd0, an1}, 32'hFE);
        check("zero_d0_ca", {25'd0, ca1}, 32'h40);
        repeat (DIV) step();
        check("zero_d1_an", {24'd0, an1}, 32'hFF);

        // Asynchronous reset in the middle of digit 5's slot
        write_word(32'h7654_3210);
        wait_an0(8'hDF, "wait_d5");
        #2 rst = 1'b0;
        #1;
        check("async_an", {24'd0, an0}, 32'hFF);
        check("async_ca", {25'd0, ca0}, 32'h7F);
        check("async_blank_an", {24'd0, an1}, 32'hFF);
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1 rst = 1'b1;
        step();
        check("restart_an", {24'd0, an0}, 32'hFE);
        check("restart_ca", {25'd0, ca0}, 32'h40);
        repeat (40) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/seg_display_ctrl.md
Name: seg_display_ctrl

Overview:
- Downstream consumer of the bus controller's seven-segment MMIO port (oSeg/oSegWe, word at 0x0000_7f08).
- Holds the last written 32-bit word and time-multiplexes it onto an 8-digit common-anode display as 8 hex nibbles, digit 0 = bits [3:0].
- Sits at top level between the bus controller and the board pins.
- Owns the display register, refresh prescaler, digit scanner and registered pin outputs.

Parameters:
- SCAN_DIV, 100000, clock cycles per digit slot; legal range ≥2. Benches use 4.
- BLANK_LZ, 0, when 1, leading-zero digits are blanked. Digit 0 is never blanked.

Ports:
- clk  input  1  system clock; single clock domain
- rst  input  1  asynchronous, active-low reset
- iSeg  input  32  write data from the bus controller
- iSegWe  input  1  write strobe, one cycle per accepted store
- oAn  output  8  digit anodes, active-low, one-hot-low while scanning
- oCa  output  7  segments {g,f,e,d,c,b,a}, active-low
- oDp  output  1  decimal point, active-low; held 1 (off)

Behaviour:
- Reset (rst=0, async):
  - display register = 0, prescaler = 0, digit index = 0
  - oAn = 8'hFF, oCa = 7'h7F, oDp = 1
- Write:
  - iSegWe=1 at a rising edge loads iSeg into the display register at that edge.
  - No handshake or backpressure: every strobe is accepted.
  - Back-to-back strobes: the last one wins.
  - iSeg is ignored while iSegWe=0.
- Prescaler:
  - Counts 0..SCAN_DIV-1 and wraps to 0.
  - On the wrap cycle the digit index advances 0→1→…→7→0.
- Output register: oAn, oCa and oDp are registered. They are updated every cycle from the current digit index and display register.
  - Output latency from an index change is 1 cycle.
  - Output latency from iSegWe is 2 cycles: 1 cycle to load the register, 1 cycle to register the output.
  - A write mid-slot changes the active digit's segments within that slot. The scan is not restarted.
- First edge after reset release drives oAn = 8'hFE with digit 0 of value 0, i.e. oCa = 7'h40.
- Anodes: oAn = ~(8'b1 << idx), unless the digit is blanked, in which case oAn = 8'hFF for that slot.
- Blanking: when BLANK_LZ=1, digit i (i≥1) is blanked iff nibbles i..7 are all zero.
- Hex decode (active-low oCa):
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
  - 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E
- Simultaneous write and index wrap in the same cycle: both take effect. The next output shows the new digit index with the new data.
- Reset asserted mid-scan: all state and outputs return to reset values immediately, without waiting for a clock edge.

Decomposition:
- Shared package BusPkg:
  - type_Data (32-bit)
  - P_SEG address constant, so the bus controller and this block share one definition
  - type_Nibble (4-bit)
  - type_SegCode (7-bit)
- One natural sub-module, seg_hex_decode: combinational type_Nibble → type_SegCode using the table above.
- The prescaler, scanner and output registers stay in seg_display_ctrl.

Test Plan:
- Reset: hold rst=0 for 3 cycles → oAn=FF, oCa=7F, oDp=1. Release rst → after 1 edge, oAn=FE, oCa=40.
- Scan (SCAN_DIV=4): write 0x76543210 → oAn walks FE,FD,FB,…,7F, 4 cycles each, then wraps to FE. oCa per slot = 40,79,24,30,19,12,02,78.
- Write latency: write 0x0000000F while the digit-0 slot is active → oCa changes from 40 to 0E exactly 2 edges after the iSegWe edge, and the slot timing is unchanged.
- Back-to-back: iSegWe on consecutive cycles with 0xAAAAAAAA then 0x88888888 → all digits show 00. Value 08 is never shown after the second strobe's latency.
- Blanking (BLANK_LZ=1): write 0x00000A05 → digits 0,1,2 are lit (12,40,08). Slots 3–7 show oAn=FF. Write 0 → only digit 0 is lit, showing 40.
- Async reset mid-scan: assert rst while the digit-5 slot is active, between clock edges → oAn=FF and oCa=7F immediately. After release, the scan restarts at digit 0 showing 40.
